scene_renderer: RTL and testbench

- Downstream consumer of the game-state controller: takes bird, pipe and coin state words plus the VGA pixel stream coordinates, and produces one 12-bit RGB colour per active pixel.
- Latches a per-frame snapshot of game state at frame start, so objects never tear mid-frame.
- Classifies each pixel through a fixed 3-stage pipeline; output feeds the VGA DAC register.

---
 rtl/scene_pkg.sv | 72 +++++++
 rtl/scene_renderer_if.sv | 39 +++
 rtl/pipe_hit.sv | 71 +++++++
 rtl/scene_renderer.sv | 203 ++++++++++++++++++++
 tb/tb_scene_renderer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scene_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scene_pkg
// Purpose  : Shared definitions for the scene renderer: RGB colour palette,
//            field positions inside the pipe / coin / bird state words, the
//            per-pixel hit-flag record and the priority colour selector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package scene_pkg;

   // 12-bit {R,G,B} palette
   localparam logic [11:0] SKY_C       = 12'h4CF;
   localparam logic [11:0] GROUND_C    = 12'hA73;
   localparam logic [11:0] PIPE_C      = 12'h2A2;
   localparam logic [11:0] PIPE_HEAD_C = 12'h1F1;
   localparam logic [11:0] COIN_C      = 12'hFD0;
   localparam logic [11:0] BIRD_UP_C   = 12'hF80;
   localparam logic [11:0] BIRD_DN_C   = 12'hF40;

   localparam int SCREEN_W = 640;   // pipe x at or beyond this is off-screen
   localparam int GROUND_H = 16;    // game rows below this draw the ground band

   // Bird word
   localparam int BIRD_UP_BIT  = 15;
   localparam int BIRD_Y_MSB   = 9;
   localparam int BIRD_Y_LSB   = 0;

   // Pipe word: [27:20] gap height, [19:10] left x, [9:0] gap bottom y
   localparam int PIPE_GAP_MSB = 27;
   localparam int PIPE_GAP_LSB = 20;
   localparam int PIPE_X_MSB   = 19;
   localparam int PIPE_X_LSB   = 10;
   localparam int PIPE_Y_MSB   = 9;
   localparam int PIPE_Y_LSB   = 0;

   // Coin word: [31] present, [19:10] bottom y, [9:0] left x
   localparam int COIN_PRESENT_BIT = 31;
   localparam int COIN_Y_MSB   = 19;
   localparam int COIN_Y_LSB   = 10;
   localparam int COIN_X_MSB   = 9;
   localparam int COIN_X_LSB   = 0;

   typedef struct packed {
      logic bird;
      logic coin;
      logic head;   // any pipe head band
      logic body;   // any pipe body
   } hit_t;

   // Priority: bird > coin > pipe head > pipe body > ground/sky
   function automatic logic [11:0] pixel_colour(input hit_t i_hit,
                                                input logic i_bird_up,
                                                input logic i_ground);
      logic [11:0] w_c;
      if (i_hit.bird)
         w_c = i_bird_up ? BIRD_UP_C : BIRD_DN_C;
      else if (i_hit.coin)
         w_c = COIN_C;
      else if (i_hit.head)
         w_c = PIPE_HEAD_C;
      else if (i_hit.body)
         w_c = PIPE_C;
      else if (i_ground)
         w_c = GROUND_C;
      else
         w_c = SKY_C;
      return w_c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/scene_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : scene_renderer_if
// Purpose  : Bundles the game-state words, pixel stream and colour output of
//            the scene renderer.
// Ports    : frame_start, pix_valid, pix_x, pix_y, bird_y, pipe1..3, coin
//            (game side -> renderer); rgb, rgb_valid, snap_valid (renderer ->
//            DAC side).
//            modport master : producer of game state / pixel coordinates
//            modport slave  : the renderer
// Revision : 1.0 - initial release
// ============================================================================
interface scene_renderer_if;
   logic        frame_start;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [15:0] bird_y;
   logic [31:0] pipe1;
   logic [31:0] pipe2;
   logic [31:0] pipe3;
   logic [31:0] coin;
   logic [11:0] rgb;
   logic        rgb_valid;
   logic        snap_valid;

   modport master (
      output frame_start, pix_valid, pix_x, pix_y, bird_y,
             pipe1, pipe2, pipe3, coin,
      input  rgb, rgb_valid, snap_valid
   );

   modport slave (
      input  frame_start, pix_valid, pix_x, pix_y, bird_y,
             pipe1, pipe2, pipe3, coin,
      output rgb, rgb_valid, snap_valid
   );
endinterface
`default_nettype wire

// File: rtl/pipe_hit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hit
// Purpose  : Combinational classification of one pixel against one pipe:
//            body (column minus gap) and head (band of PIPE_HEAD rows at
//            either gap edge). All arithmetic is 11 bits wide so sums of
//            10-bit fields never wrap.
// Ports    : i_x    - screen column of the pixel
//            i_gy   - game row of the pixel (up-positive)
//            i_pipe - pipe word {gap, x, y}
//            o_body - pixel lies in the pipe body
//            o_head - pixel lies in a pipe head band (implies o_body)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hit
   import scene_pkg::*;
#(
   parameter int PIPE_W    = 50,
   parameter int PIPE_HEAD = 23,
   parameter int X_LIMIT   = 640
) (
   input  wire logic [9:0]  i_x,
   input  wire logic [9:0]  i_gy,
   input  wire logic [31:0] i_pipe,
   output logic             o_body,
   output logic             o_head
);

   localparam logic [10:0] c_PIPE_W  = 11'(PIPE_W);
   localparam logic [10:0] c_HEAD    = 11'(PIPE_HEAD);
   localparam logic [10:0] c_X_LIMIT = 11'(X_LIMIT);

   logic [10:0] w_x;
   logic [10:0] w_gy;
   logic [10:0] w_px;
   logic [10:0] w_py;
   logic [10:0] w_gap;
   logic [10:0] w_gap_top;
   logic [10:0] w_low_edge;
   logic        w_column;
   logic        w_in_gap;
   logic        w_low_band;
   logic        w_high_band;
   logic        w_unused_pipe;

   assign w_x   = {1'b0, i_x};
   assign w_gy  = {1'b0, i_gy};
   assign w_px  = {1'b0, i_pipe[PIPE_X_MSB:PIPE_X_LSB]};
   assign w_py  = {1'b0, i_pipe[PIPE_Y_MSB:PIPE_Y_LSB]};
   assign w_gap = {3'b000, i_pipe[PIPE_GAP_MSB:PIPE_GAP_LSB]};

   assign w_gap_top  = w_py + w_gap;
   // Lower head band starts at 0 when the gap sits closer than PIPE_HEAD to
   // the bottom of the screen, instead of wrapping to a huge value.
   assign w_low_edge = (w_py < c_HEAD) ? 11'd0 : (w_py - c_HEAD);

   // Column is inclusive at both ends to line up with the controller's
   // collision box; an x beyond the visible width is a wrapped pipe.
   assign w_column    = (w_px < c_X_LIMIT) && (w_x >= w_px) && (w_x <= w_px + c_PIPE_W);
   assign w_in_gap    = (w_gy >= w_py) && (w_gy < w_gap_top);
   assign w_low_band  = (w_gy >= w_low_edge) && (w_gy < w_py);
   assign w_high_band = (w_gy >= w_gap_top) && (w_gy < w_gap_top + c_HEAD);

   assign o_body = w_column && !w_in_gap;
   assign o_head = o_body && (w_low_band || w_high_band);

   // Reserved bits of the pipe word carry no meaning here.
   assign w_unused_pipe = ^i_pipe[31:28];

endmodule
`default_nettype wire

// File: rtl/scene_renderer.sv
`default_nettype none
// ============================================================================
// Module   : scene_renderer
// Purpose  : Turns the VGA pixel stream plus game state (bird, three pipes,
//            coin) into one 12-bit RGB colour per active pixel. Game state
//            is snapshotted on frame_start so objects never tear within a
//            frame. Fixed 3-stage pipeline, one pixel per clock, no stalls:
//              S1 : register x, game row gy and valid
//              S2 : per-object hit flags (11-bit compares)
//              S3 : priority colour mux into the output register
// Ports    : clk, rst (sync, active high)
//            bus.frame_start - snapshot load strobe
//            bus.pix_valid/pix_x/pix_y - active pixel coordinates
//            bus.bird_y, bus.pipe1..3, bus.coin - live game state
//            bus.rgb, bus.rgb_valid - colour of pixel presented 3 cycles ago
//            bus.snap_valid - a snapshot has been taken since reset
// Revision : 1.0 - initial release
// ============================================================================
module scene_renderer
   import scene_pkg::*;
#(
   parameter int BIRD_X    = 40,
   parameter int BIRD_W    = 16,
   parameter int BIRD_H    = 16,
   parameter int PIPE_W    = 50,
   parameter int PIPE_HEAD = 23,
   parameter int COIN_LEN  = 16,
   parameter int SCREEN_H  = 480
) (
   input  wire logic       clk,
   input  wire logic       rst,
   scene_renderer_if.slave bus
);

   localparam int          c_N_PIPES   = 3;
   localparam logic [9:0]  c_GY_TOP    = 10'(SCREEN_H - 1);
   localparam logic [9:0]  c_GROUND_H  = 10'(GROUND_H);
   localparam logic [10:0] c_BIRD_X_LO = 11'(BIRD_X);
   localparam logic [10:0] c_BIRD_X_HI = 11'(BIRD_X + BIRD_W);
   localparam logic [10:0] c_BIRD_H    = 11'(BIRD_H);
   localparam logic [10:0] c_COIN_LEN  = 11'(COIN_LEN);

   // ------------------------------------------------------------------
   // Per-frame snapshot
   // ------------------------------------------------------------------
   logic [15:0]                 r_bird_y;
   logic [c_N_PIPES-1:0][31:0]  r_pipe;
   logic [31:0]                 r_coin;
   logic                        r_snap_valid;
   logic [c_N_PIPES-1:0][31:0]  w_pipe_in;

   assign w_pipe_in[0] = bus.pipe1;
   assign w_pipe_in[1] = bus.pipe2;
   assign w_pipe_in[2] = bus.pipe3;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bird_y     <= '0;
         r_pipe       <= '0;
         r_coin       <= '0;
         r_snap_valid <= 1'b0;
      end else if (bus.frame_start) begin
         r_bird_y     <= bus.bird_y;
         r_pipe       <= w_pipe_in;
         r_coin       <= bus.coin;
         r_snap_valid <= 1'b1;
      end
   end

   // A pixel arriving together with frame_start must already see the new
   // snapshot. Its geometry is evaluated in S2, one cycle later, when the
   // shadows hold the new values; the flags S1 captures directly come from
   // this bypass view.
   logic w_snap_eff;
   logic w_bird_up_eff;

   assign w_snap_eff    = bus.frame_start | r_snap_valid;
   assign w_bird_up_eff = bus.frame_start ? bus.bird_y[BIRD_UP_BIT]
                                          : r_bird_y[BIRD_UP_BIT];

   // ------------------------------------------------------------------
   // S1: pixel coordinates into game space
   // ------------------------------------------------------------------
   logic       r_s1_valid;
   logic       r_s1_snap;
   logic       r_s1_bird_up;
   logic [9:0] r_s1_x;
   logic [9:0] r_s1_gy;
   logic [9:0] w_gy;

   assign w_gy = c_GY_TOP - bus.pix_y;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid   <= 1'b0;
         r_s1_snap    <= 1'b0;
         r_s1_bird_up <= 1'b0;
         r_s1_x       <= '0;
         r_s1_gy      <= '0;
      end else begin
         r_s1_valid   <= bus.pix_valid;
         r_s1_snap    <= w_snap_eff;
         r_s1_bird_up <= w_bird_up_eff;
         r_s1_x       <= bus.pix_x;
         r_s1_gy      <= w_gy;
      end
   end

   // ------------------------------------------------------------------
   // S2: hit flags
   // ------------------------------------------------------------------
   logic [10:0]          w_x11;
   logic [10:0]          w_gy11;
   logic [10:0]          w_by;
   logic [10:0]          w_cx;
   logic [10:0]          w_cy;
   logic [c_N_PIPES-1:0] w_body;
   logic [c_N_PIPES-1:0] w_head;
   hit_t                 w_hit;

   assign w_x11  = {1'b0, r_s1_x};
   assign w_gy11 = {1'b0, r_s1_gy};
   assign w_by   = {1'b0, r_bird_y[BIRD_Y_MSB:BIRD_Y_LSB]};
   assign w_cx   = {1'b0, r_coin[COIN_X_MSB:COIN_X_LSB]};
   assign w_cy   = {1'b0, r_coin[COIN_Y_MSB:COIN_Y_LSB]};

   generate
      for (genvar g = 0; g < c_N_PIPES; g++) begin : g_pipe
         pipe_hit #(
            .PIPE_W    (PIPE_W),
            .PIPE_HEAD (PIPE_HEAD),
            .X_LIMIT   (SCREEN_W)
         ) u_pipe_hit (
            .i_x    (r_s1_x),
            .i_gy   (r_s1_gy),
            .i_pipe (r_pipe[g]),
            .o_body (w_body[g]),
            .o_head (w_head[g])
         );
      end
   endgenerate

   // The 11-bit upper bounds keep a bird or coin near y=1023 from aliasing
   // onto the bottom rows of the screen.
   always_comb begin
      w_hit      = '0;
      w_hit.bird = (w_x11 >= c_BIRD_X_LO) && (w_x11 < c_BIRD_X_HI)
                && (w_gy11 >= w_by) && (w_gy11 < w_by + c_BIRD_H);
      w_hit.coin = r_coin[COIN_PRESENT_BIT]
                && (w_x11 >= w_cx) && (w_x11 < w_cx + c_COIN_LEN)
                && (w_gy11 >= w_cy) && (w_gy11 < w_cy + c_COIN_LEN);
      // Head from any pipe outranks body from any other overlapping pipe.
      w_hit.head = |w_head;
      w_hit.body = |w_body;
   end

   logic r_s2_valid;
   hit_t r_s2_hit;
   logic r_s2_bird_up;
   logic r_s2_ground;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid   <= 1'b0;
         r_s2_hit     <= '0;
         r_s2_bird_up <= 1'b0;
         r_s2_ground  <= 1'b0;
      end else begin
         r_s2_valid   <= r_s1_valid;
         // Without a snapshot only sky/ground may be drawn.
         r_s2_hit     <= r_s1_snap ? w_hit : '0;
         r_s2_bird_up <= r_s1_bird_up;
         r_s2_ground  <= (r_s1_gy < c_GROUND_H);
      end
   end

   // ------------------------------------------------------------------
   // S3: colour mux, blanking when no pixel
   // ------------------------------------------------------------------
   logic [11:0] r_rgb;
   logic        r_rgb_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rgb       <= 12'h000;
         r_rgb_valid <= 1'b0;
      end else begin
         r_rgb_valid <= r_s2_valid;
         r_rgb       <= r_s2_valid ? pixel_colour(r_s2_hit, r_s2_bird_up, r_s2_ground)
                                   : 12'h000;
      end
   end

   assign bus.rgb        = r_rgb;
   assign bus.rgb_valid  = r_rgb_valid;
   assign bus.snap_valid = r_snap_valid;

   // Bits of the snapshot words that no stage interprets.
   logic w_unused_bits;
   assign w_unused_bits = ^{r_bird_y[14:10], r_coin[30:20]};

endmodule
`default_nettype wire

// File: tb/tb_scene_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scene_renderer
// Purpose  : Self-checking bench for scene_renderer. Directed scenes from the
//            test plan plus a randomized stream compared against a
//            behavioural model of the rendering rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scene_renderer;
   import scene_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scene_renderer_if bus();

   scene_renderer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [11:0] rgb;
      logic        val;
      int          x;
      int          y;
      int          step;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          step    = 0;

   logic [15:0] t_bird;
   logic [31:0] t_pipe [3];
   logic [31:0] t_coin;
   logic [15:0] m_bird;
   logic [31:0] m_pipe [3];
   logic [31:0] m_coin;
   logic        m_snap;

   function automatic logic [31:0] mk_pipe(input int gap, input int x, input int y);
      return {4'b0000, gap[7:0], x[9:0], y[9:0]};
   endfunction

   function automatic logic [31:0] mk_coin(input logic present, input int y, input int x);
      return {present, 11'b0, y[9:0], x[9:0]};
   endfunction

   // Colour of screen pixel (x,y) under the model snapshot.
   function automatic logic [11:0] ref_colour(input int x, input int y);
      int gy, by, cx, cy, px, py, gap;
      bit head, body;
      logic [11:0] bg;
      gy = 479 - y;
      bg = (gy < 16) ? GROUND_C : SKY_C;
      if (!m_snap) return bg;
      by = int'(m_bird[9:0]);
      if (x >= 40 && x < 56 && gy >= by && gy < by + 16)
         return m_bird[15] ? BIRD_UP_C : BIRD_DN_C;
      cx = int'(m_coin[9:0]);
      cy = int'(m_coin[19:10]);
      if (m_coin[31] && x >= cx && x < cx + 16 && gy >= cy && gy < cy + 16)
         return COIN_C;
      head = 0;
      body = 0;
      for (int p = 0; p < 3; p++) begin
         gap = int'(m_pipe[p][27:20]);
         px  = int'(m_pipe[p][19:10]);
         py  = int'(m_pipe[p][9:0]);
         if (px < 640 && x >= px && x <= px + 50 && (gy < py || gy >= py + gap)) begin
            body = 1;
            if ((gy >= py - 23 && gy < py) || (gy >= py + gap && gy < py + gap + 23))
               head = 1;
         end
      end
      if (head) return PIPE_HEAD_C;
      if (body) return PIPE_C;
      return bg;
   endfunction

   // One clock: check what is due now, then drive the next inputs.
   task automatic cycle(input logic fs, input logic pv, input int x, input int y,
                        input logic r, input logic use_want, input logic [11:0] want);
      exp_t e;
      exp_t n;
      @(posedge clk);
      #1;
      e = q.pop_front();
      n_tests++;
      assert (bus.rgb_valid === e.val) else begin
         n_fail++;
         $error("FAIL rgb_valid step %0d (x=%0d y=%0d): got %b want %b",
                e.step, e.x, e.y, bus.rgb_valid, e.val);
      end
      n_tests++;
      assert (bus.rgb === e.rgb) else begin
         n_fail++;
         $error("FAIL rgb step %0d (x=%0d y=%0d): got %h want %h",
                e.step, e.x, e.y, bus.rgb, e.rgb);
      end
      n_tests++;
      assert (bus.snap_valid === m_snap) else begin
         n_fail++;
         $error("FAIL snap_valid step %0d: got %b want %b", step, bus.snap_valid, m_snap);
      end

      step++;
      rst             = r;
      bus.frame_start = fs;
      bus.pix_valid   = pv;
      bus.pix_x       = 10'(x);
      bus.pix_y       = 10'(y);
      bus.bird_y      = t_bird;
      bus.pipe1       = t_pipe[0];
      bus.pipe2       = t_pipe[1];
      bus.pipe3       = t_pipe[2];
      bus.coin        = t_coin;

      n.x = -1; n.y = -1; n.step = -1; n.val = 1'b0; n.rgb = 12'h000;
      if (r) begin
         m_snap = 1'b0;
         m_bird = '0;
         m_coin = '0;
         foreach (m_pipe[i]) m_pipe[i] = '0;
         q.delete();
         q.push_back(n);
         q.push_back(n);
      end else if (fs) begin
         m_bird = t_bird;
         m_coin = t_coin;
         foreach (m_pipe[i]) m_pipe[i] = t_pipe[i];
         m_snap = 1'b1;
      end
      n.x = x; n.y = y; n.step = step;
      if (!r && pv) begin
         n.val = 1'b1;
         n.rgb = use_want ? want : ref_colour(x, y);
      end
      q.push_back(n);
   endtask

   task automatic pix(input int x, input int gy, input logic [11:0] want);
      cycle(1'b0, 1'b1, x, 479 - gy, 1'b0, 1'b1, want);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 12'h000);
   endtask

   task automatic frame();
      cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 12'h000);
   endtask

   initial begin
      exp_t inv;
      inv.rgb = 12'h000; inv.val = 1'b0; inv.x = -1; inv.y = -1; inv.step = -1;
      for (int i = 0; i < 3; i++) q.push_back(inv);
      m_snap = 1'b0; m_bird = '0; m_coin = '0;
      foreach (m_pipe[i]) m_pipe[i] = '0;
      t_bird = '0;
      t_coin = '0;
      foreach (t_pipe[i]) t_pipe[i] = mk_pipe(0, 1020, 0);
      rst = 1'b1;
      bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
      bus.pix_x = '0; bus.pix_y = '0; bus.bird_y = '0;
      bus.pipe1 = '0; bus.pipe2 = '0; bus.pipe3 = '0; bus.coin = '0;

      // Reset, then five pixels with no snapshot taken yet.
      cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, 1'b1, 100, 100, 1'b0, 1'b1, SKY_C);
      cycle(1'b0, 1'b1, 100, 470, 1'b0, 1'b1, GROUND_C);
      cycle(1'b0, 1'b1, 45,  234, 1'b0, 1'b1, SKY_C);
      cycle(1'b0, 1'b1, 5,   479, 1'b0, 1'b1, GROUND_C);
      cycle(1'b0, 1'b1, 639, 0,   1'b0, 1'b1, SKY_C);
      idle(3);

      // Bird, rising and falling.
      t_bird = 16'h80F0;
      frame();
      pix(45, 245, BIRD_UP_C);
      pix(56, 245, SKY_C);
      pix(40, 240, BIRD_UP_C);
      pix(55, 256, SKY_C);
      t_bird = 16'h00F0;
      frame();
      pix(45, 245, BIRD_DN_C);
      pix(39, 245, SKY_C);

      // Pipe 1: gap 150..249, heads 127..149 and 250..272.
      t_pipe[0] = mk_pipe(100, 200, 150);
      frame();
      for (int k = 0; k < 2; k++) begin
         pix(200 + 50 * k, 149, PIPE_HEAD_C);
         pix(200 + 50 * k, 120, PIPE_C);
         pix(200 + 50 * k, 200, SKY_C);
         pix(200 + 50 * k, 250, PIPE_HEAD_C);
         pix(200 + 50 * k, 280, PIPE_C);
      end
      pix(251, 120, SKY_C);
      pix(199, 149, SKY_C);
      pix(220, 10, PIPE_C);

      // Wrapped pipe never draws.
      t_pipe[0] = mk_pipe(100, 1020, 150);
      frame();
      for (int x = 0; x <= 30; x++) pix(x, 120, SKY_C);
      pix(10, 140, SKY_C);

      // Coin absent, present, and under the bird.
      t_coin = mk_coin(1'b0, 300, 100);
      frame();
      pix(105, 305, SKY_C);
      t_coin = mk_coin(1'b1, 300, 100);
      frame();
      pix(105, 305, COIN_C);
      pix(116, 305, SKY_C);
      t_coin = mk_coin(1'b1, 240, 40);
      frame();
      pix(45, 245, BIRD_DN_C);
      t_coin = mk_coin(1'b0, 0, 0);

      // Live inputs change without frame_start: snapshot must hold.
      t_pipe[0] = mk_pipe(100, 200, 150);
      frame();
      pix(200, 120, PIPE_C);
      t_pipe[0] = mk_pipe(100, 400, 150);
      pix(200, 120, PIPE_C);
      pix(400, 120, SKY_C);
      cycle(1'b1, 1'b1, 400, 479 - 120, 1'b0, 1'b1, PIPE_C);
      pix(200, 120, SKY_C);

      // Bird near the top of the 10-bit range must not wrap to the bottom.
      t_bird = 16'h03FA;
      frame();
      pix(45, 0, GROUND_C);
      pix(45, 5, GROUND_C);

      // Randomized stream against the model.
      for (int i = 0; i < 400; i++) begin
         logic fs, pv;
         int x, y;
         if ($urandom_range(0, 3) == 0) begin
            t_bird = {$urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                      ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023))
                                                  : 10'($urandom_range(0, 479))};
            foreach (t_pipe[p])
               t_pipe[p] = mk_pipe($urandom_range(0, 255),
                                   ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1023)
                                                               : $urandom_range(0, 639),
                                   $urandom_range(0, 479));
            t_coin = mk_coin($urandom_range(0, 1) == 1, $urandom_range(0, 479),
                             $urandom_range(0, 639));
         end
         fs = ($urandom_range(0, 15) == 0);
         pv = ($urandom_range(0, 4) != 0);
         x  = ($urandom_range(0, 1) == 1) ? $urandom_range(30, 70) : $urandom_range(0, 639);
         y  = $urandom_range(0, 479);
         cycle(fs, pv, x, y, 1'b0, 1'b0, 12'h000);
      end

      // Reset in the middle of a streaming run.
      t_bird = 16'h80F0;
      foreach (t_pipe[p]) t_pipe[p] = mk_pipe(0, 1020, 0);
      t_coin = mk_coin(1'b0, 0, 0);
      frame();
      for (int i = 0; i < 4; i++) pix(45, 245, BIRD_UP_C);
      cycle(1'b0, 1'b1, 45, 479 - 245, 1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 5; i++) pix(45, 245, SKY_C);
      frame();
      pix(45, 245, BIRD_UP_C);
      pix(45, 245, BIRD_UP_C);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
